// File: rtl/zxuno_scandoubler.sv
// Line-doubling scan converter: ULA 15.6 kHz RGB/csync in, 31 kHz RGB with separate hsync/vsync out.
// Two-bank line buffer; one bank is written at 7 MHz while the other is replayed twice at 14 MHz.
module zxuno_scandoubler #(
  parameter int unsigned ADDR_W    = 9,
  parameter int unsigned HSYNC_W   = 54,
  parameter int unsigned VSYNC_MIN = 256,
  parameter int unsigned MIN_LINE  = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [2:0] r_in,
  input  logic [2:0] g_in,
  input  logic [2:0] b_in,
  input  logic       csync_in,
  output logic [2:0] r_out,
  output logic [2:0] g_out,
  output logic [2:0] b_out,
  output logic       hsync_out,
  output logic       vsync_out
);

  localparam int unsigned PIX_W = 9;
  localparam int unsigned DEPTH = 2 ** (ADDR_W + 1);
  localparam int unsigned LC_W  = $clog2(VSYNC_MIN + 1);

  localparam logic [ADDR_W-1:0] CNT_MAX = '1;
  localparam logic [ADDR_W-1:0] LEN_RST = ADDR_W'(448);
  localparam logic [ADDR_W-1:0] MIN_LEN = ADDR_W'(MIN_LINE);
  localparam logic [ADDR_W-1:0] HS_LEN  = ADDR_W'(HSYNC_W);
  localparam logic [LC_W-1:0]   LC_MAX  = LC_W'(VSYNC_MIN);

  logic [1:0]        div_q, div_d;
  logic [PIX_W-1:0]  pix_q;
  logic              csync_q, csync_d1_q;
  logic [ADDR_W-1:0] wcnt_q, wcnt_d;
  logic              wbank_q, wbank_d;
  logic [ADDR_W-1:0] line_len_q, line_len_d;
  logic              rbank_q, rbank_d;
  logic [ADDR_W-1:0] rcnt_q, rcnt_d;
  logic [LC_W-1:0]   low_cnt_q, low_cnt_d;
  logic              vs_flag_q, vs_flag_d;
  logic              hs1_q, hs1_d;
  logic [PIX_W-1:0]  rgb_out_q, rgb_out_d;
  logic              hsync_out_q, hsync_out_d;
  logic              vsync_out_q, vsync_out_d;

  logic [PIX_W-1:0]  mem [DEPTH];
  logic [PIX_W-1:0]  ram_q;

  logic wce_c, rce_c, line_start_c, valid_start_c, sync_rise_c;

  assign wce_c         = (div_q == 2'd3);
  assign rce_c         = div_q[0];
  assign line_start_c  = csync_d1_q & ~csync_q;
  assign sync_rise_c   = ~csync_d1_q & csync_q;
  assign valid_start_c = line_start_c & (wcnt_q >= MIN_LEN);

  // Next-state for counters, banks, sync detection and the output stage
  always_comb begin
    div_d       = div_q + 2'd1;
    wcnt_d      = wcnt_q;
    wbank_d     = wbank_q;
    line_len_d  = line_len_q;
    rbank_d     = rbank_q;
    rcnt_d      = rcnt_q;
    low_cnt_d   = low_cnt_q;
    vs_flag_d   = vs_flag_q;
    hs1_d       = (rcnt_q < HS_LEN);
    rgb_out_d   = pix_q;
    hsync_out_d = csync_q;
    vsync_out_d = 1'b1;

    if (wce_c && (wcnt_q != CNT_MAX)) begin
      wcnt_d = wcnt_q + ADDR_W'(1);
    end
    if (line_start_c) begin
      wcnt_d = '0;
    end

    if (rce_c) begin
      rcnt_d = (rcnt_q == (line_len_q - ADDR_W'(1))) ? '0 : rcnt_q + ADDR_W'(1);
    end
    // A real line start swaps banks and restarts the replay; short serrations only rewind the writer
    if (valid_start_c) begin
      line_len_d = wcnt_q;
      wbank_d    = ~wbank_q;
      rbank_d    = wbank_q;
      rcnt_d     = '0;
    end

    if (sync_rise_c) begin
      vs_flag_d = (low_cnt_q >= LC_MAX);
      low_cnt_d = '0;
    end else if (!csync_q && (low_cnt_q != LC_MAX)) begin
      low_cnt_d = low_cnt_q + LC_W'(1);
    end

    if (enable) begin
      rgb_out_d   = hs1_q ? '0 : ram_q;
      hsync_out_d = ~hs1_q;
      vsync_out_d = ~vs_flag_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q       <= '0;
      pix_q       <= '0;
      csync_q     <= 1'b1;
      csync_d1_q  <= 1'b1;
      wcnt_q      <= '0;
      wbank_q     <= 1'b0;
      line_len_q  <= LEN_RST;
      rbank_q     <= 1'b1;
      rcnt_q      <= '0;
      low_cnt_q   <= '0;
      vs_flag_q   <= 1'b0;
      hs1_q       <= 1'b0;
      rgb_out_q   <= '0;
      hsync_out_q <= 1'b1;
      vsync_out_q <= 1'b1;
    end else begin
      div_q       <= div_d;
      pix_q       <= {r_in, g_in, b_in};
      csync_q     <= csync_in;
      csync_d1_q  <= csync_q;
      wcnt_q      <= wcnt_d;
      wbank_q     <= wbank_d;
      line_len_q  <= line_len_d;
      rbank_q     <= rbank_d;
      rcnt_q      <= rcnt_d;
      low_cnt_q   <= low_cnt_d;
      vs_flag_q   <= vs_flag_d;
      hs1_q       <= hs1_d;
      rgb_out_q   <= rgb_out_d;
      hsync_out_q <= hsync_out_d;
      vsync_out_q <= vsync_out_d;
    end
  end

  // Line buffer: synchronous write and read, no reset on the storage
  always_ff @(posedge clk) begin
    if (wce_c) begin
      mem[{wbank_q, wcnt_q}] <= pix_q;
    end
    ram_q <= mem[{rbank_q, rcnt_q}];
  end

  assign r_out     = rgb_out_q[8:6];
  assign g_out     = rgb_out_q[5:3];
  assign b_out     = rgb_out_q[2:0];
  assign hsync_out = hsync_out_q;
  assign vsync_out = vsync_out_q;

endmodule

// File: tb/tb_zxuno_scandoubler.sv
// Directed bench for zxuno_scandoubler: line replay, serration, overlong line, vsync, bypass and reset.
module tb_zxuno_scandoubler;

  localparam int HS_W = 54;

  logic       clk, rst_n, enable, csync_in;
  logic [2:0] r_in, g_in, b_in;
  logic [2:0] r_out, g_out, b_out;
  logic       hsync_out, vsync_out;

  int checks = 0;
  int errors = 0;
  int ls_count = 0;
  int cyc;

  typedef struct {
    logic       en;
    logic [8:0] px;
    logic       cs;
    logic [2:0] er, eg, eb;
    logic       ehs, evs;
  } vec_t;
  vec_t tbl [5];

  zxuno_scandoubler dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .r_in(r_in), .g_in(g_in), .b_in(b_in), .csync_in(csync_in),
    .r_out(r_out), .g_out(g_out), .b_out(b_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge count since reset release; wce falls on edges where this is a multiple of 4
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [8:0] pix(input int n, input int off);
    if (n >= 512) return 9'h1AA;
    return 9'((n + off) % 512);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic align();
    do begin
      @(posedge clk); #1;
    end while (cyc % 4 != 0);
  endtask

  // One ULA pixel period (4 clk); pins change just after a wce-aligned edge
  task automatic drv_step(input logic cs, input logic [8:0] px);
    csync_in = cs;
    {r_in, g_in, b_in} = px;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic drv_line(input int npix, input int low_steps, input int off);
    ls_count++;
    for (int n = 0; n < npix; n++) drv_step((n < low_steps) ? 1'b0 : 1'b1, pix(n, off));
  endtask

  // Wait for line start k, then check nl replayed lines of len pixels from the hsync rising edge
  task automatic check_lines(input int k, input int len, input int off, input int nl, input string name);
    int i, bad;
    logic [8:0] epx;
    logic ehs;
    wait (ls_count >= k);
    repeat (6) @(negedge clk);
    check({name, "_restart_hs"}, 32'(hsync_out), 0);
    i = 0;
    while (hsync_out !== 1'b1 && i < 2 * len + 16) begin
      @(negedge clk); i++;
    end
    check({name, "_rise"}, 32'(hsync_out), 1);
    if (hsync_out !== 1'b1) return;
    for (int ln = 0; ln < nl; ln++) begin
      bad = 0;
      for (int s = 0; s < 2 * len; s++) begin
        if (s < 2 * (len - HS_W)) begin
          ehs = 1'b1; epx = pix(HS_W + s / 2, off);
        end else begin
          ehs = 1'b0; epx = 9'd0;
        end
        if ({r_out, g_out, b_out} !== epx || hsync_out !== ehs) bad++;
        @(negedge clk);
      end
      check($sformatf("%s_line%0d_bad_samples", name, ln), bad, 0);
    end
    check({name, "_next_rise"}, 32'(hsync_out), 1);
  endtask

  task automatic pulse(input int low_steps, input int high_steps, input logic pre, input logic post,
                       input string name);
    for (int n = 0; n < low_steps; n++) drv_step(1'b0, 9'o070);
    check({name, "_before_rise"}, 32'(vsync_out), 32'(pre));
    drv_step(1'b1, 9'o070);
    check({name, "_after_rise"}, 32'(vsync_out), 32'(post));
    for (int n = 1; n < high_steps; n++) drv_step(1'b1, 9'o070);
  endtask

  initial begin
    int n;
    tbl[0] = '{1'b0, 9'o123, 1'b1, 3'd1, 3'd2, 3'd3, 1'b1, 1'b1};
    tbl[1] = '{1'b0, 9'o765, 1'b0, 3'd7, 3'd6, 3'd5, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 9'o000, 1'b1, 3'd0, 3'd0, 3'd0, 1'b1, 1'b1};
    tbl[3] = '{1'b0, 9'o777, 1'b0, 3'd7, 3'd7, 3'd7, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 9'o504, 1'b1, 3'd5, 3'd0, 3'd4, 1'b1, 1'b1};

    rst_n = 1'b0; enable = 1'b1; csync_in = 1'b1;
    {r_in, g_in, b_in} = 9'o777;
    repeat (3) @(negedge clk);
    check("rst_rgb", 32'({r_out, g_out, b_out}), 0);
    check("rst_hsync", 32'(hsync_out), 1);
    check("rst_vsync", 32'(vsync_out), 1);
    rst_n = 1'b1;

    // Idle after reset: default 448-pixel line, 54-pixel hsync
    n = 0;
    while (hsync_out !== 1'b0 && n < 2000) begin @(negedge clk); n++; end
    n = 0;
    while (hsync_out !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    check("idle_rise", 32'(hsync_out), 1);
    n = 0;
    while (hsync_out === 1'b1 && n < 2000) begin @(negedge clk); n++; end
    check("idle_high_clks", n, 788);
    n = 0;
    while (hsync_out === 1'b0 && n < 2000) begin @(negedge clk); n++; end
    check("idle_low_clks", n, 108);

    align();
    fork
      begin
        drv_line(448, 32, 0);
        drv_line(480, 32, 100);
        drv_line(40, 8, 0);
        drv_line(448, 8, 300);
        drv_line(600, 32, 3);
        drv_line(600, 32, 0);
      end
      begin
        check_lines(2, 448, 0, 2, "replay448");
        check_lines(3, 480, 100, 1, "serration");
        check_lines(5, 448, 300, 1, "post_serr");
        check_lines(6, 511, 3, 2, "overlong");
      end
    join

    align();
    pulse(63, 20, 1'b1, 1'b1, "vs252");
    pulse(75, 20, 1'b1, 1'b0, "vs300");
    pulse(32, 20, 1'b0, 1'b1, "vs128");
    pulse(64, 20, 1'b1, 1'b0, "vs256");

    enable = 1'b0;
    drv_step(1'b1, 9'o070);
    check("bypass_vsync", 32'(vsync_out), 1);
    enable = 1'b1;
    drv_step(1'b1, 9'o070);
    check("vs_flag_held", 32'(vsync_out), 0);

    foreach (tbl[i]) begin
      enable = tbl[i].en;
      csync_in = tbl[i].cs;
      {r_in, g_in, b_in} = tbl[i].px;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check($sformatf("byp%0d_r", i), 32'(r_out), 32'(tbl[i].er));
      check($sformatf("byp%0d_g", i), 32'(g_out), 32'(tbl[i].eg));
      check($sformatf("byp%0d_b", i), 32'(b_out), 32'(tbl[i].eb));
      check($sformatf("byp%0d_hs", i), 32'(hsync_out), 32'(tbl[i].ehs));
      check($sformatf("byp%0d_vs", i), 32'(vsync_out), 32'(tbl[i].evs));
      @(posedge clk); #1;
    end

    // Asynchronous reset mid-line, checked before the next clock edge
    enable = 1'b0;
    drv_step(1'b0, 9'o777);
    check("pre_rst_rgb", 32'({r_out, g_out, b_out}), 32'(9'o777));
    check("pre_rst_hs", 32'(hsync_out), 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_rgb", 32'({r_out, g_out, b_out}), 0);
    check("async_rst_hs", 32'(hsync_out), 1);
    check("async_rst_vs", 32'(vsync_out), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
